// File: rtl/periph_bridge_pkg.sv
// Shared types and constants for the OBI -> AXI-Lite peripheral bridge.
// Slot offsets are also consumed by the software header generator.
package periph_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RESP
  } bridge_state_e;

  localparam logic [31:0] DEF_ADDR_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_8000;
  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

  localparam logic [31:0] SLOT_GPIO  = 32'h0000_0000;
  localparam logic [31:0] SLOT_TIMER = 32'h0000_1000;
  localparam logic [31:0] SLOT_UART0 = 32'h0000_2000;
  localparam logic [31:0] SLOT_UART1 = 32'h0000_3000;
  localparam logic [31:0] SLOT_QSPI  = 32'h0000_4000;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/obi_axil_periph_bridge.sv
// Single-outstanding bridge from the CV32E40P OBI data port to the AXI-Lite
// peripheral subsystem; out-of-window accesses complete locally with an error.
module obi_axil_periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req,
  output logic        data_gnt,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  output logic        m_rready
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    strb_q;
  logic          err_q, aw_done_q, w_done_q;
  logic          hit, aw_hs, w_hs;

  assign hit   = addr_hit(data_addr, ADDR_BASE, ADDR_MASK);
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;

  // Gated by rst_n so the grant is low while reset is held.
  assign data_gnt = data_req && (state_q == IDLE) && rst_n;

  // NOTE: state and datapath registers use non-blocking assignments and an
  // async active-low reset, so every flop clears the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (data_gnt) begin
        addr_q    <= {data_addr[31:2], 2'b00};
        wdata_q   <= data_wdata;
        strb_q    <= data_be;
        err_q     <= !hit;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (!hit) rdata_q <= data_we ? '0 : ERR_RDATA;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (state_q == WR_RESP && m_bvalid) err_q <= 1'b0;
      if (state_q == RD_RESP && m_rvalid) begin
        rdata_q <= m_rdata;
        err_q   <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_req) state_d = !hit ? RESP : (data_we ? WR_REQ : RD_REQ);
      WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      WR_RESP: if (m_bvalid)  state_d = RESP;
      RD_REQ:  if (m_arready) state_d = RD_RESP;
      RD_RESP: if (m_rvalid)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    case (state_q)
      WR_REQ: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
      end
      WR_RESP: m_bready  = 1'b1;
      RD_REQ:  m_arvalid = 1'b1;
      RD_RESP: m_rready  = 1'b1;
      RESP: begin
        data_rvalid = 1'b1;
        data_err    = err_q;
      end
      default: ;
    endcase
  end

  // Address/data held from grant until IDLE: downstream decode is address-driven.
  assign m_awaddr   = addr_q;
  assign m_araddr   = addr_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = strb_q;
  assign data_rdata = rdata_q;

endmodule

// File: tb/tb_obi_axil_periph_bridge.sv
// Randomized self-checking bench for obi_axil_periph_bridge with a
// delay-configurable AXI-Lite slave and a transaction-level reference model.
module tb_obi_axil_periph_bridge;
  import periph_bridge_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_8000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic        m_arready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  obi_axil_periph_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave configuration for the current transaction
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [31:0] rd_value = '0;

  int  aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit  aw_got, w_got, b_pend, r_pend;
  int  aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, valid_cycles = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  bit  p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv;
  logic [31:0] p_rdata;

  // Monitor first (uses last cycle's ready values), then the slave decides
  // this cycle's ready/valid for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rv = 0;
    end else begin
      if (p_awv && !p_awr) check("awvalid_held", m_awvalid, 1);
      if (p_wv && !p_wr)   check("wvalid_held", m_wvalid, 1);
      if (p_arv && !p_arr) check("arvalid_held", m_arvalid, 1);
      if (p_rv) begin
        check("rvalid_pulse", data_rvalid, 0);
        check("rdata_hold", data_rdata, p_rdata);
      end
      if (m_awvalid || m_wvalid || m_bready) begin
        check("awaddr_stable", m_awaddr, exp_addr);
        check("wdata_stable", m_wdata, exp_wdata);
        check("wstrb_stable", m_wstrb, exp_be);
      end
      if (m_arvalid || m_rready) check("araddr_stable", m_araddr, exp_addr);
      if (m_awvalid || m_wvalid || m_arvalid) valid_cycles++;
      p_awv = m_awvalid; p_wv = m_wvalid; p_arv = m_arvalid;
      p_rv = data_rvalid; p_rdata = data_rdata;

      // Responses first so B/R never appear in the same cycle as their request
      if (b_pend) begin
        if (b_wait < b_delay) begin b_wait++; m_bvalid = 0; end
        else begin
          m_bvalid = 1;
          if (m_bready) begin b_hs++; b_pend = 0; b_wait = 0; end
        end
      end else m_bvalid = 0;
      if (r_pend) begin
        if (r_wait < r_delay) begin r_wait++; m_rvalid = 0; end
        else begin
          m_rvalid = 1; m_rdata = rd_value;
          if (m_rready) begin r_hs++; r_pend = 0; r_wait = 0; end
        end
      end else m_rvalid = 0;

      if (m_awvalid) begin
        if (aw_wait < aw_delay) begin aw_wait++; m_awready = 0; end
        else begin m_awready = 1; aw_hs++; aw_got = 1; aw_wait = 0; last_awaddr = m_awaddr; end
      end else m_awready = 1'($urandom_range(0, 1));
      if (m_wvalid) begin
        if (w_wait < w_delay) begin w_wait++; m_wready = 0; end
        else begin
          m_wready = 1; w_hs++; w_got = 1; w_wait = 0;
          last_wdata = m_wdata; last_wstrb = m_wstrb;
        end
      end else m_wready = 1'($urandom_range(0, 1));
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
      if (m_arvalid) begin
        if (ar_wait < ar_delay) begin ar_wait++; m_arready = 0; end
        else begin m_arready = 1; ar_hs++; r_pend = 1; ar_wait = 0; last_araddr = m_araddr; end
      end else m_arready = 1'($urandom_range(0, 1));
      p_awr = m_awready; p_wr = m_wready; p_arr = m_arready;
    end
  end

  // One OBI transaction; expectations come from the address window rule and
  // the slave delays. hold keeps data_req high past the response.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit hold);
    int gnt_cyc, start_cyc, rv_cyc, exp_lat;
    int aw0, w0, b0, ar0, r0, v0;
    bit hit, got;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs; v0 = valid_cycles;
    @(posedge clk); #1;
    data_req = 1; data_we = we; data_addr = addr; data_wdata = wdata; data_be = be;
    start_cyc = cyc;
    hit = ((addr & MASK) == BASE);
    if (!hit)    exp_lat = 1;
    else if (we) exp_lat = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
    else         exp_lat = 3 + ar_delay + r_delay;

    got = 0; gnt_cyc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (data_gnt) begin got = 1; gnt_cyc = cyc; end
    end
    check("gnt_cycle", gnt_cyc, start_cyc);
    if (!got) return;
    exp_addr = {addr[31:2], 2'b00}; exp_wdata = wdata; exp_be = be;

    @(posedge clk); #1;
    if (!hold) begin
      data_req = 0; data_we = 1'($urandom_range(0, 1));
      data_addr = $urandom; data_wdata = $urandom; data_be = 4'($urandom);
    end
    got = 0; rv_cyc = -1;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (data_rvalid) begin got = 1; rv_cyc = cyc; end
      if (data_req) check("no_gnt_busy", data_gnt, 0);
    end
    check("rvalid_seen", got, 1);
    if (!got) return;
    check("latency", rv_cyc - gnt_cyc, exp_lat);
    check("err", data_err, !hit);
    if (!hit)     check("rdata_miss", data_rdata, we ? 32'h0 : ERRD);
    else if (!we) check("rdata", data_rdata, rd_value);
    check("aw_hs", aw_hs - aw0, hit && we);
    check("w_hs",  w_hs - w0,   hit && we);
    check("b_hs",  b_hs - b0,   hit && we);
    check("ar_hs", ar_hs - ar0, hit && !we);
    check("r_hs",  r_hs - r0,   hit && !we);
    if (!hit) check("no_axi_valid", valid_cycles - v0, 0);
    if (hit && we) begin
      check("awaddr", last_awaddr, {addr[31:2], 2'b00});
      check("wdata", last_wdata, wdata);
      check("wstrb", last_wstrb, be);
    end
    if (hit && !we) check("araddr", last_araddr, {addr[31:2], 2'b00});
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  logic [31:0] slots [5] = '{SLOT_GPIO, SLOT_TIMER, SLOT_UART0, SLOT_UART1, SLOT_QSPI};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    bit hold;
    logic [31:0] addr;
    int sel;

    #2 rst_n = 0;
    #20;
    check("rst_ctrl", {data_gnt, data_rvalid, data_err, m_awvalid, m_wvalid,
                       m_bready, m_arvalid, m_rready}, 0);
    check("rst_rdata", data_rdata, 0);
    check("rst_awaddr", m_awaddr, 0);
    check("rst_wdata", {m_wdata[31:4], m_wdata[3:0] | m_wstrb}, 0);
    @(posedge clk); #1 rst_n = 1;

    // Directed cases
    set_delays(0, 0, 0, 0, 0);
    run_txn(1, 32'h1000_0004, 32'h0000_A5A5, 4'hF, 0);
    rd_value = 32'h0000_0041; set_delays(0, 0, 0, 0, 5);
    run_txn(0, 32'h1000_2008, 32'h0, 4'hF, 0);
    set_delays(3, 0, 0, 0, 0);
    run_txn(1, 32'h1000_1010, 32'h1234_5678, 4'h3, 0);
    set_delays(0, 3, 1, 0, 0);
    run_txn(1, 32'h1000_3014, 32'h8765_4321, 4'hC, 0);
    set_delays(0, 0, 0, 0, 0);
    run_txn(0, 32'h2000_0000, 32'h0, 4'hF, 0);
    run_txn(1, 32'h1000_8000, 32'hFFFF_FFFF, 4'hF, 0);
    rd_value = 32'hCAFE_0001;
    run_txn(1, 32'h1000_4000, 32'h0BAD_F00D, 4'hF, 1);
    run_txn(0, 32'h1000_4004, 32'h0, 4'hF, 0);

    // Abort a read while waiting for R
    rd_value = 32'h5555_AAAA; set_delays(0, 0, 0, 0, 10);
    @(posedge clk); #1;
    data_req = 1; data_we = 0; data_addr = 32'h1000_0010; exp_addr = 32'h1000_0010;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = data_gnt; end
    check("abort_gnt", got, 1);
    @(posedge clk); #1 data_req = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = m_rready; end
    check("abort_in_rd_resp", got, 1);
    #2 rst_n = 0; data_req = 1;
    #1;
    check("abort_ctrl", {data_gnt, data_rvalid, data_err, m_awvalid, m_wvalid,
                         m_bready, m_arvalid, m_rready}, 0);
    check("abort_addr", m_araddr, 0);
    check("abort_rdata", data_rdata, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1; data_req = 0;
    rd_value = 32'h0000_7777; set_delays(0, 0, 0, 0, 0);
    run_txn(0, 32'h1000_0000, 32'h0, 4'hF, 0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      if (sel < 5) addr = BASE + slots[sel] + (32'($urandom_range(0, 1023)) << 2)
                          + 32'($urandom_range(0, 3));
      else         addr = $urandom;
      set_delays($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom_range(0, 4), $urandom_range(0, 4));
      rd_value = $urandom;
      hold = (n != 39) && ($urandom_range(0, 1) == 1);
      run_txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), hold);
    end

    @(posedge clk); #1 data_req = 0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obi_axil_periph_bridge.md
Name: obi_axil_periph_bridge

Overview:
Converts the CV32E40P OBI data-bus port into the single-outstanding AXI-Lite subset consumed by the peripheral subsystem (GPIO/timer/UART0/UART1/QSPI window). It sits directly upstream of the peripheral wrapper and drives its s_aw*/s_w*/s_b*/s_ar*/s_r* channels. Out-of-window accesses complete locally with an error and never reach AXI. Exactly one transaction is in flight at a time.

Parameters:
ADDR_BASE, 32'h1000_0000, base of peripheral window
ADDR_MASK, 32'hFFFF_8000, address bits compared against ADDR_BASE
ERR_RDATA, 32'hDEAD_BEEF, rdata returned on decode error

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active-low
data_req  in  1  OBI request
data_gnt  out  1  OBI grant
data_we  in  1  1=write
data_be  in  4  byte enables
data_addr  in  32  byte address
data_wdata  in  32  write data
data_rvalid  out  1  OBI response valid (reads and writes)
data_rdata  out  32  read data
data_err  out  1  decode error
m_awaddr  out  32  AXI write address
m_awvalid  out  1
m_awready  in  1
m_wdata  out  32
m_wstrb  out  4
m_wvalid  out  1
m_wready  in  1
m_bvalid  in  1
m_bready  out  1
m_araddr  out  32
m_arvalid  out  1
m_arready  in  1
m_rdata  in  32
m_rvalid  in  1
m_rready  out  1

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. All outputs 0 in reset; state IDLE; internal addr/data/strb registers 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP.
- data_gnt = data_req && state==IDLE (combinational). No grant in any other state.
- On grant: latch {data_addr[31:2],2'b00}, data_wdata, data_be, data_we. Hit = ((data_addr & ADDR_MASK) == ADDR_BASE).
- Miss: go to RESP with err_q=1, rdata_q=ERR_RDATA (writes: rdata_q=0); no AXI activity.
- Hit write -> WR_REQ: m_awvalid and m_wvalid both 1 from the next cycle. Each drops independently after its own handshake (aw_done/w_done flags). Either order and same-cycle are legal. Leave when both done -> WR_RESP.
- WR_RESP: m_bready=1; on m_bvalid -> RESP, err_q=0.
- Hit read -> RD_REQ: m_arvalid=1 until m_arready -> RD_RESP.
- RD_RESP: m_rready=1; on m_rvalid capture m_rdata -> RESP.
- RESP: data_rvalid=1 for exactly one cycle with data_rdata=rdata_q, data_err=err_q -> IDLE. data_rdata holds its last value otherwise.
- m_awaddr/m_araddr/m_wdata/m_wstrb are registered. They stay stable from the grant until return to IDLE, because the downstream decode is address-driven.
- Minimum latency, slave always ready with 1-cycle response: write gnt@0, AW/W hs@1, bvalid@2, data_rvalid@3. Read gnt@0, AR hs@1, rvalid@2, data_rvalid@3. Miss: data_rvalid@1.
- valid never deasserts before its ready (AXI rule). Unrelated ready/valid inputs seen in the wrong state are ignored.
- data_req may stay high through RESP; the next grant is issued at the earliest in the IDLE cycle after RESP.
- Reset mid-transaction aborts immediately to IDLE. The downstream slave is reset by the same rst_n.
- No timeout; a hung slave stalls the core (by design).

Decomposition:
- Package periph_bridge_pkg holds:
  - bridge_state_e enum (6 states)
  - default ADDR_BASE/ADDR_MASK/ERR_RDATA constants
  - peripheral slot offsets (GPIO 0x0000, TIMER 0x1000, UART0 0x2000, UART1 0x3000, QSPI 0x4000), shared with the software header generator.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- Write 0x1000_0004 data 0x0000_A5A5 be 4'hF, slave ready always -> one AW/W handshake, m_awaddr=0x1000_0004, m_wstrb=4'hF; data_rvalid @ cycle 3 with data_err=0.
- Read 0x1000_2008, slave returns m_rdata=0x0000_0041 after 5-cycle rvalid delay -> data_rdata=0x0000_0041 exactly one cycle after the R handshake; m_araddr stable throughout.
- Write with m_wready 3 cycles before m_awready (and then reversed) -> each valid drops only after its own handshake; exactly one B handshake; one data_rvalid.
- Read 0x2000_0000 (out of window) -> no m_arvalid ever; data_rvalid @ cycle 1 with data_err=1, data_rdata=0xDEAD_BEEF.
- Back-to-back: data_req held high for write then read -> second data_gnt only in IDLE after the first RESP; never two transactions outstanding.
- rst_n asserted while in RD_RESP -> all outputs 0 asynchronously; after release, a new read to 0x1000_0000 completes normally.
